// File: rtl/page_mode_dram_ctrl.sv
// Page-mode DRAM initiator: single-byte host requests, open-row reuse,
// one-per-cycle page-hit reads and enforced activate/precharge delays.
module page_mode_dram_ctrl #(
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned PAGE_IDLE = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_we,
  input  logic [7:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_page_open,
  output logic       o_dram_cs,
  output logic       o_dram_we,
  output logic [3:0] o_dram_row,
  output logic [3:0] o_dram_col,
  output logic [7:0] o_dram_din,
  input  logic [7:0] i_dram_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACT  = 2'd1,
    S_OPEN = 2'd2,
    S_PRE  = 2'd3
  } state_t;

  // Timers count down to zero, so they are loaded with the delay minus one.
  localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);
  localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);
  localparam logic [7:0] IDLE_LIM = 8'(PAGE_IDLE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_tmr;
  logic [3:0]  w_tmr_nxt;
  logic [7:0]  r_idle;
  logic [7:0]  w_idle_nxt;
  logic        r_drain;
  logic        w_drain_nxt;

  logic        r_cs;
  logic        w_cs_nxt;
  logic        r_we;
  logic        w_we_nxt;
  logic [3:0]  r_row;
  logic [3:0]  w_row_nxt;
  logic [3:0]  r_col;
  logic [3:0]  w_col_nxt;
  logic [7:0]  r_din;
  logic [7:0]  w_din_nxt;

  logic        r_vld_p0;
  logic        r_vld_p1;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;

  logic        w_hit;
  logic        w_empty;
  logic        w_accept;
  logic        w_miss;
  logic        w_drain_any;
  logic        w_idle_done;

  assign w_hit       = (i_req_addr[7:4] == r_row);
  assign w_empty     = !r_vld_p0 && !r_vld_p1;
  assign w_accept    = (r_state == S_OPEN) && i_req_valid && w_hit && !r_drain;
  assign w_miss      = (r_state == S_OPEN) && i_req_valid && !w_hit;
  // A miss seen this cycle counts as draining, so an empty pipeline can
  // leave for precharge without spending an extra cycle.
  assign w_drain_any = r_drain || w_miss;
  assign w_idle_done = !w_accept && (r_idle >= IDLE_LIM) && w_empty;

  // Next-state and next registered-output values; outputs hold by default
  // except dram_we, which is a single-cycle write strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_idle_nxt  = r_idle;
    w_drain_nxt = r_drain;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_din_nxt   = r_din;
    w_we_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = S_ACT;
          w_row_nxt   = i_req_addr[7:4];
          w_tmr_nxt   = RCD_LOAD;
        end
      end
      S_ACT: begin
        if (r_tmr == 4'd0) begin
          w_state_nxt = S_OPEN;
          w_idle_nxt  = 8'd0;
        end else begin
          w_tmr_nxt = r_tmr - 4'd1;
        end
      end
      S_OPEN: begin
        if (w_accept) begin
          w_idle_nxt = 8'd0;
          w_col_nxt  = i_req_addr[3:0];
          if (i_req_we) begin
            w_we_nxt  = 1'b1;
            w_din_nxt = i_req_wdata;
          end
        end else if (r_idle < IDLE_LIM) begin
          w_idle_nxt = r_idle + 8'd1;
        end
        if (w_miss) begin
          w_drain_nxt = 1'b1;
        end
        // The row only closes once no read tag is in flight.
        if (w_empty && (w_drain_any || w_idle_done)) begin
          w_state_nxt = S_PRE;
          w_tmr_nxt   = RP_LOAD;
        end
      end
      S_PRE: begin
        if (r_tmr == 4'd0) begin
          if (r_drain) begin
            w_state_nxt = S_ACT;
            w_row_nxt   = i_req_addr[7:4];
            w_tmr_nxt   = RCD_LOAD;
            w_drain_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_tmr_nxt = r_tmr - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_cs_nxt = (w_state_nxt == S_ACT) || (w_state_nxt == S_OPEN);
  end

  // State, timers and registered DRAM-side pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= 4'd0;
      r_idle  <= 8'd0;
      r_drain <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_row   <= 4'd0;
      r_col   <= 4'd0;
      r_din   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_idle  <= w_idle_nxt;
      r_drain <= w_drain_nxt;
      r_cs    <= w_cs_nxt;
      r_we    <= w_we_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_din   <= w_din_nxt;
    end
  end

  // Read tag pipeline: p0 = column issued, p1 = DRAM has registered data,
  // then the response is captured; reset drops in-flight tags silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'd0;
    end else begin
      r_vld_p0    <= w_accept && !i_req_we;
      r_vld_p1    <= r_vld_p0;
      r_rsp_valid <= r_vld_p1;
      if (r_vld_p1) begin
        r_rsp_rdata <= i_dram_dout;
      end
    end
  end

  assign o_req_ready = w_accept;
  assign o_page_open = (r_state == S_ACT) || (r_state == S_OPEN);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_dram_cs   = r_cs;
  assign o_dram_we   = r_we;
  assign o_dram_row  = r_row;
  assign o_dram_col  = r_col;
  assign o_dram_din  = r_din;

endmodule

// File: tb/tb_page_mode_dram_ctrl.sv
// Directed bench for page_mode_dram_ctrl with a behavioural 16x16x8 DRAM.
module tb_page_mode_dram_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       page_open;
  logic       dram_cs;
  logic       dram_we;
  logic [3:0] dram_row;
  logic [3:0] dram_col;
  logic [7:0] dram_din;
  logic [7:0] dram_dout;

  int checks;
  int failures;

  page_mode_dram_ctrl #(.T_RCD(2), .T_RP(2), .PAGE_IDLE(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_page_open (page_open),
    .o_dram_cs   (dram_cs),
    .o_dram_we   (dram_we),
    .o_dram_row  (dram_row),
    .o_dram_col  (dram_col),
    .o_dram_din  (dram_din),
    .i_dram_dout (dram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: unwritten cells read as addr ^ 0x5A; output clears while cs low.
  bit [7:0]   mem [256];
  bit [255:0] wr_map;
  logic [7:0] mdl_addr;

  // DRAM samples pins on each rising edge.
  always @(posedge clk) begin
    mdl_addr = {dram_row, dram_col};
    if (dram_cs) begin
      if (dram_we) begin
        mem[mdl_addr]    = dram_din;
        wr_map[mdl_addr] = 1'b1;
      end else begin
        dram_dout <= wr_map[mdl_addr] ? mem[mdl_addr] : (mdl_addr ^ 8'h5A);
      end
    end else begin
      dram_dout <= 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"},     32'(req_ready), 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({pfx, "_cs"},        32'(dram_cs),   32'd0);
    chk({pfx, "_we"},        32'(dram_we),   32'd0);
    chk({pfx, "_row"},       32'(dram_row),  32'd0);
    chk({pfx, "_col"},       32'(dram_col),  32'd0);
    chk({pfx, "_din"},       32'(dram_din),  32'd0);
    chk({pfx, "_page_open"}, 32'(page_open), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();
    chk_zero("rst0");
    rst_n = 1'b1;

    // Cold write 0xA5 to 0x37, then read it back.
    drive(1'b1, 1'b1, 8'h37, 8'hA5);
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    step();
    chk("act_cs_rise", 32'(dram_cs), 32'd1);
    chk("act_page_open", 32'(page_open), 32'd1);
    chk("act_row", 32'(dram_row), 32'd3);
    chk("act1_ready", 32'(req_ready), 32'd0);
    step();
    chk("act2_cs", 32'(dram_cs), 32'd1);
    chk("act2_ready", 32'(req_ready), 32'd0);
    step();
    chk("open_ready", 32'(req_ready), 32'd1);
    step();
    chk("wr_we", 32'(dram_we), 32'd1);
    chk("wr_col", 32'(dram_col), 32'd7);
    chk("wr_din", 32'(dram_din), 32'hA5);
    drive(1'b1, 1'b0, 8'h37, 8'h00);
    #1;
    chk("rd_ready", 32'(req_ready), 32'd1);
    step();
    chk("rd_we", 32'(dram_we), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("rd_lat1_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("rd_lat2_valid", 32'(rsp_valid), 32'd1);
    chk("rd_lat2_data", 32'(rsp_rdata), 32'hA5);
    step();
    chk("rd_pulse_end", 32'(rsp_valid), 32'd0);

    // Back-to-back page hits: four writes then four reads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'(48 + i), 8'(16 + i));
      #1;
      chk("b2b_wr_ready", 32'(req_ready), 32'd1);
      step();
      chk("b2b_wr_we", 32'(dram_we), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(48 + i), 8'h00);
      #1;
      chk("b2b_rd_ready", 32'(req_ready), 32'd1);
      step();
      if (i >= 2) begin
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp_data", 32'(rsp_rdata), 32'(16 + i - 2));
      end else begin
        chk("b2b_rsp_quiet", 32'(rsp_valid), 32'd0);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("b2b_rsp_valid3", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp_data3", 32'(rsp_rdata), 32'h12);
    step();
    chk("b2b_rsp_valid4", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp_data4", 32'(rsp_rdata), 32'h13);
    step();
    chk("b2b_rsp_end", 32'(rsp_valid), 32'd0);

    // Row miss to 0x52 with two reads in flight.
    drive(1'b1, 1'b0, 8'h31, 8'h00);
    #1;
    chk("miss_rd0_ready", 32'(req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 8'h32, 8'h00);
    #1;
    chk("miss_rd1_ready", 32'(req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 8'h52, 8'h00);
    #1;
    chk("miss_ready0", 32'(req_ready), 32'd0);
    step();
    chk("miss_rsp0_valid", 32'(rsp_valid), 32'd1);
    chk("miss_rsp0_data", 32'(rsp_rdata), 32'h11);
    chk("miss_cs_hold0", 32'(dram_cs), 32'd1);
    chk("miss_ready1", 32'(req_ready), 32'd0);
    step();
    chk("miss_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("miss_rsp1_data", 32'(rsp_rdata), 32'h12);
    chk("miss_cs_hold1", 32'(dram_cs), 32'd1);
    chk("miss_ready2", 32'(req_ready), 32'd0);
    step();
    chk("pre_cs_low0", 32'(dram_cs), 32'd0);
    chk("pre_row_keep", 32'(dram_row), 32'd3);
    chk("pre_rsp_quiet", 32'(rsp_valid), 32'd0);
    chk("pre_ready", 32'(req_ready), 32'd0);
    step();
    chk("pre_cs_low1", 32'(dram_cs), 32'd0);
    step();
    chk("miss_act_cs", 32'(dram_cs), 32'd1);
    chk("miss_act_row", 32'(dram_row), 32'd5);
    chk("miss_act_ready0", 32'(req_ready), 32'd0);
    step();
    chk("miss_act_cs2", 32'(dram_cs), 32'd1);
    chk("miss_act_ready1", 32'(req_ready), 32'd0);
    step();
    chk("miss_open_ready", 32'(req_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("miss_rd_lat1", 32'(rsp_valid), 32'd0);
    step();
    chk("miss_rd_valid", 32'(rsp_valid), 32'd1);
    chk("miss_rd_data", 32'(rsp_rdata), 32'h08);

    // Idle close: eight idle OPEN cycles after the last accept.
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("idle7_cs", 32'(dram_cs), 32'd1);
    chk("idle7_page_open", 32'(page_open), 32'd1);
    step();
    chk("idle_pre_cs0", 32'(dram_cs), 32'd0);
    chk("idle_pre_page_open", 32'(page_open), 32'd0);
    step();
    chk("idle_pre_cs1", 32'(dram_cs), 32'd0);
    step();
    chk("idle_done_cs", 32'(dram_cs), 32'd0);
    chk("idle_done_page_open", 32'(page_open), 32'd0);

    // Reset during ACT.
    drive(1'b1, 1'b0, 8'h37, 8'h00);
    step();
    chk("reopen_cs", 32'(dram_cs), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_act_cs", 32'(dram_cs), 32'd0);
    chk("rst_act_page_open", 32'(page_open), 32'd0);
    chk("rst_act_row", 32'(dram_row), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_act_cs", 32'(dram_cs), 32'd1);
    chk("post_rst_act_row", 32'(dram_row), 32'd3);
    step();
    step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Reset with a read tag in flight.
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // A fresh request reopens the row and reads the earlier write.
    drive(1'b1, 1'b0, 8'h37, 8'h00);
    step();
    chk("final_act_cs", 32'(dram_cs), 32'd1);
    chk("final_act_row", 32'(dram_row), 32'd3);
    step();
    step();
    chk("final_ready", 32'(req_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("final_lat1", 32'(rsp_valid), 32'd0);
    step();
    chk("final_valid", 32'(rsp_valid), 32'd1);
    chk("final_data", 32'(rsp_rdata), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/page_mode_dram_ctrl.md
# page_mode_dram_ctrl

Initiator-side controller for the team's 16×16×8 page-mode DRAM. Accepts single-byte read/write requests on a valid/ready host port and drives the DRAM's `cs`/`we`/`row`/`col`/`data_in` pins. It keeps a row open across consecutive same-row (page-hit) accesses, pipelines page-hit reads at one per cycle, and enforces precharge and activate delays on row misses. Sits between any bus master and the DRAM instance.

## Interface

**Parameters**

- `T_RCD`, 2, cycles spent in ACT before the first column access; legal range 1..15.
- `T_RP`, 2, cycles `dram_cs` is held low in PRE; legal range 1..15.
- `PAGE_IDLE`, 8, consecutive OPEN cycles without an accepted request before auto-close; legal range 1..255.

**Ports**

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: controller accepts on `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 8: `[7:4]` = row, `[3:0]` = col.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle read-data strobe; read responses return in request order.
- `rsp_rdata` out 8: read data, valid while `rsp_valid` is high.
- `page_open` out 1: high in states ACT and OPEN.
- `dram_cs` out 1: DRAM chip select.
- `dram_we` out 1: DRAM write enable.
- `dram_row` out 4: DRAM row address.
- `dram_col` out 4: DRAM column address.
- `dram_din` out 8: DRAM write data.
- `dram_dout` in 8: DRAM read data. The DRAM registers this output on the `clk` edge where it samples `cs=1, we=0`. It clears to 0 when `cs` falls.

## Operation

**Registered outputs.** All DRAM-side outputs and `rsp_*` are registered.

**State machine:** IDLE, ACT, OPEN, PRE.

- **IDLE**
  - `dram_cs=0`, `req_ready=0`.
  - If `req_valid` is high, latch `dram_row = req_addr[7:4]` and go to ACT. The request is not consumed.
- **ACT**
  - `dram_cs=1`, `dram_we=0`.
  - Lasts exactly `T_RCD` cycles, then go to OPEN.
- **OPEN**
  - `dram_cs=1`.
  - `req_ready = req_valid_row_hit && !drain`, where `req_valid_row_hit` means `req_addr[7:4] == dram_row`.
  - On an accepted write: `dram_we=1`, `dram_col` and `dram_din` are loaded from the request for exactly one cycle.
  - On an accepted read: `dram_we=0`, `dram_col` is loaded, and a tag is pushed into a 2-stage read pipeline.
  - With no accept: `dram_we=0`; `dram_col` and `dram_din` hold. This is an idle read and produces no response.
- **Row miss** (`req_valid` high with a different row, in OPEN)
  - Set `drain`; `req_ready=0`.
  - Once the read pipeline is empty, go to PRE with `dram_row` unchanged.
  - PRE then proceeds to ACT with the new row.
- **Idle close**
  - An idle counter increments each OPEN cycle with no accept and clears on any accept.
  - When it reaches `PAGE_IDLE` with the pipeline empty, go to PRE, then to IDLE.
- **PRE**
  - `dram_cs=0`, `dram_we=0`.
  - Lasts exactly `T_RP` cycles.
  - If a row miss is pending, go to ACT and load `dram_row` from `req_addr[7:4]`. Otherwise go to IDLE.

**Read pipeline.**

- Stage 0 is set on the accept edge E0.
- The DRAM samples at E1.
- The controller captures `dram_dout` into `rsp_rdata` at E2 and asserts `rsp_valid` for one cycle starting at E2.

**Boundary rules.**

- `dram_cs` never falls while any read tag is in flight.
- A write accepted at E0 followed by a read of the same address accepted at E1 returns the new data.
- `req_valid` dropping during ACT still completes ACT, then OPEN begins its idle count.
- A miss request held through PRE/ACT is accepted in the first OPEN cycle.

**Reset.** Asynchronous reset forces state IDLE, clears all counters and the pipeline, and sets the following output values:

- `req_ready=0`
- `rsp_valid=0`
- `rsp_rdata=0`
- `dram_cs=0`
- `dram_we=0`
- `dram_row=0`
- `dram_col=0`
- `dram_din=0`
- `page_open=0`

In-flight reads are discarded with no response.

## Timing

- **IDLE → first accept:** `1 + T_RCD` cycles after `req_valid` is sampled (3 with defaults).
- **Page-hit throughput:** one request per cycle, reads and writes mixed.
- **Read latency:** `rsp_valid` is high 2 cycles after the accept edge.
- **Row-miss penalty:** drain (0–2 cycles) + `T_RP` + `T_RCD`, before the miss request's accept cycle.
- **Write latency:** the DRAM commits the write 1 cycle after accept; writes produce no response.

## Test plan

- **Reset.** Hold `rst_n` low mid-traffic → every output is 0 and no `rsp_valid` pulse follows deassertion.
- **Cold write then read.** From IDLE, write 0xA5 to 0x37, then read 0x37:
  - `dram_cs` rises one cycle after `req_valid`.
  - The first accept comes after 2 ACT cycles.
  - The read returns `rsp_rdata=0xA5` two cycles after its accept.
- **Back-to-back page hits.** Write 0x10..0x13 to 0x30..0x33, then read 0x30..0x33 on consecutive cycles → `rsp_valid` high 4 consecutive cycles with 0x10, 0x11, 0x12, 0x13 in order.
- **Row miss with reads in flight.** Row 3 open with reads in flight, then request a read of 0x52:
  - `req_ready` stays low until both responses are delivered.
  - `dram_cs` is low exactly 2 cycles.
  - `dram_row` becomes 5.
  - The read is accepted after 2 ACT cycles and returns the DRAM content at 0x52.
- **Idle close.** After the last access, 8 idle OPEN cycles → PRE for 2 cycles, then IDLE with `page_open=0` and `dram_cs=0`.
- **Reset during traffic.** Assert `rst_n` low during ACT and during a pending read → `dram_cs` drops immediately, no response is emitted, and a subsequent request reopens the row normally.
